// File: rtl/shift_seq.sv
// Sequential 16-bit shifter/rotator: one single-bit step per cycle under an IDLE/SHIFT/DONE FSM.
// Optional build macro SHIFT_SEQ_EARLY_EXIT_EN ends SHIFT early once R and C are both zero.
module shift_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] abus,
  input  logic [2:0]  op,
  input  logic        cin,
  input  logic [3:0]  amt,
  output logic [15:0] outbus,
  output logic        cout,
  output logic        overflow,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] OP_SHL = 3'b001;
  localparam logic [2:0] OP_SHR = 3'b010;
  localparam logic [2:0] OP_SAR = 3'b011;
  localparam logic [2:0] OP_RLC = 3'b100;
  localparam logic [2:0] OP_RRC = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_op;
  logic [3:0]  r_cnt;
  logic [15:0] r_r;
  logic        r_c;
  logic        r_ov;

  logic [17:0] w_step;
  logic [15:0] w_step_r;
  logic        w_step_c;
  logic        w_step_ov;
  logic [3:0]  w_cnt_dec;
  logic        w_op_valid;
  logic        w_go_shift;

  // One single-bit step; returns {R, C, ov} after the step.
  function automatic logic [17:0] step_fn(input logic [2:0]  f_op,
                                          input logic [15:0] f_r,
                                          input logic        f_c);
    logic [15:0] nr;
    logic        nc;
    logic        nov;
    nr  = f_r;
    nc  = f_c;
    nov = 1'b0;
    case (f_op)
      OP_SHL: begin
        nr  = {f_r[14:0], 1'b0};
        nc  = f_r[15];
        nov = f_r[15] ^ f_r[14];
      end
      OP_SHR: begin
        nr  = {1'b0, f_r[15:1]};
        nc  = f_r[0];
        nov = f_r[15];
      end
      OP_SAR: begin
        nr  = (f_r == 16'hFFFF) ? 16'h0000 : {f_r[15], f_r[15:1]};
        nc  = f_r[0];
        nov = 1'b0;
      end
      OP_RLC: begin
        nr  = {f_r[14:0], f_c};
        nc  = f_r[15];
        nov = f_r[15] ^ f_r[14];
      end
      OP_RRC: begin
        nr  = {f_c, f_r[15:1]};
        nc  = f_r[0];
        nov = f_r[15] ^ f_c;
      end
      default: ;
    endcase
    return {nr, nc, nov};
  endfunction

  assign w_step     = step_fn(r_op, r_r, r_c);
  assign w_step_r   = w_step[17:2];
  assign w_step_c   = w_step[1];
  assign w_step_ov  = w_step[0];
  assign w_cnt_dec  = r_cnt - 4'd1;
  assign w_op_valid = (op >= OP_SHL) && (op <= OP_RRC);
  assign w_go_shift = w_op_valid && (amt != 4'd0);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = w_go_shift ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        if (w_cnt_dec == 4'd0) w_state_nxt = ST_DONE;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        // All-zero R and C are a fixed point of every op, so the rest of the count changes nothing.
        else if ((w_step_r == 16'h0000) && !w_step_c) w_state_nxt = ST_DONE;
`endif
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != ST_IDLE);
    done = (r_state == ST_DONE);
  end

  // NOP/invalid ops clear the result; amt=0 passes abus through with a zero carry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op  <= 3'b000;
      r_cnt <= 4'd0;
      r_r   <= 16'h0000;
      r_c   <= 1'b0;
      r_ov  <= 1'b0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_op  <= op;
      r_cnt <= amt;
      r_r   <= w_op_valid ? abus : 16'h0000;
      r_c   <= w_go_shift ? cin : 1'b0;
      r_ov  <= 1'b0;
    end else if (r_state == ST_SHIFT) begin
      r_cnt <= w_cnt_dec;
      r_r   <= w_step_r;
      r_c   <= w_step_c;
      r_ov  <= r_ov | w_step_ov;
    end
  end

  assign outbus   = r_r;
  assign cout     = r_c;
  assign overflow = r_ov;

endmodule

// File: tb/tb_shift_seq.sv
// Randomized self-checking bench for shift_seq against an arithmetic reference model.
// Define SHIFT_SEQ_EARLY_EXIT_EN here as well when building the RTL with it.
module tb_shift_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] abus;
  logic [2:0]  op;
  logic        cin;
  logic [3:0]  amt;
  logic [15:0] outbus;
  logic        cout;
  logic        overflow;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  shift_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abus     (abus),
    .op       (op),
    .cin      (cin),
    .amt      (amt),
    .outbus   (outbus),
    .cout     (cout),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Result and start-to-done latency computed directly from the operation rules.
  task automatic model(input int m_op, input int a, input int c_in, input int m_amt,
                       output int r, output int c, output int ov, output int lat);
    int old;
    r = 0; c = 0; ov = 0; lat = 1;
    if (m_op < 1 || m_op > 5) return;
    r = a;
    if (m_amt == 0) return;
    c = c_in;
    lat = m_amt + 1;
    for (int i = 0; i < m_amt; i++) begin
      old = r;
      case (m_op)
        1: begin r = (old * 2) % 65536; c = old / 32768;
                 if (((old / 32768) % 2) != ((old / 16384) % 2)) ov = 1; end
        2: begin r = old / 2; c = old % 2; if (old >= 32768) ov = 1; end
        3: begin r = (old == 65535) ? 0 : (old / 2 + ((old >= 32768) ? 32768 : 0)); c = old % 2; end
        4: begin r = (old * 2) % 65536 + c; if (((old / 32768) % 2) != ((old / 16384) % 2)) ov = 1;
                 c = old / 32768; end
        default: begin r = old / 2 + c * 32768; if ((old >= 32768) != (c == 1)) ov = 1; c = old % 2; end
      endcase
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
      if (r == 0 && c == 0 && lat == m_amt + 1) lat = i + 2;
`endif
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] t_op, input logic [15:0] t_a,
                        input logic t_cin, input logic [3:0] t_amt, input bit poke_busy);
    int er, ec, eov, elat, n;
    bit got;
    model(int'(t_op), int'(t_a), int'(t_cin), int'(t_amt), er, ec, eov, elat);
    @(negedge clk);
    op = t_op; abus = t_a; cin = t_cin; amt = t_amt; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
      else begin
        check({tag, "_busy"}, busy, 1'b1);
        if (poke_busy && n == 1) begin
          start = 1'b1; op = 3'b001; abus = ~t_a; cin = ~t_cin; amt = 4'd1;
        end else start = 1'b0;
      end
    end
    if (!got) begin
      check({tag, "_timeout"}, 0, 1);
      start = 1'b0;
      return;
    end
    check({tag, "_lat"}, n, elat);
    check({tag, "_out"}, outbus, er);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ov"}, overflow, eov);
    // A start during the done cycle must be dropped; results must hold in IDLE.
    start = 1'b1; op = 3'b010; abus = 16'h5A5A; amt = 4'd3;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_idle_done"}, done, 1'b0);
    check({tag, "_hold_out"}, outbus, er);
    check({tag, "_hold_cout"}, cout, ec);
    check({tag, "_hold_ov"}, overflow, eov);
  endtask

  initial begin
    int seen_done;
    reset = 1'b1; start = 1'b0; abus = 16'h0; op = 3'b0; cin = 1'b0; amt = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_out", outbus, 16'h0000);
    check("rst_cout", cout, 1'b0);
    check("rst_ov", overflow, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    reset = 1'b0;

    run_op("shl_1234", 3'b001, 16'h1234, 1'b0, 4'd3,  1'b1);
    run_op("shr_800f", 3'b010, 16'h800F, 1'b0, 4'd4,  1'b0);
    run_op("sar_8004", 3'b011, 16'h8004, 1'b0, 4'd2,  1'b0);
    run_op("sar_ffff", 3'b011, 16'hFFFF, 1'b0, 4'd1,  1'b0);
    run_op("rlc_8000", 3'b100, 16'h8000, 1'b1, 4'd1,  1'b0);
    run_op("rrc_0001", 3'b101, 16'h0001, 1'b1, 4'd2,  1'b1);
    run_op("amt0_shl", 3'b001, 16'hABCD, 1'b1, 4'd0,  1'b0);
    run_op("nop",      3'b000, 16'hBEEF, 1'b1, 4'd5,  1'b0);
    run_op("inval",    3'b111, 16'hBEEF, 1'b1, 4'd5,  1'b0);
    run_op("shr_0003", 3'b010, 16'h0003, 1'b0, 4'd15, 1'b0);

    // Reset two cycles into a long operation aborts it with no done pulse.
    @(negedge clk);
    op = 3'b001; abus = 16'hF0F0; cin = 1'b1; amt = 4'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_out", outbus, 16'h0000);
    check("abort_cout", cout, 1'b0);
    check("abort_ov", overflow, 1'b0);
    check("abort_busy", busy, 1'b0);
    reset = 1'b0;
    seen_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("abort_no_done", seen_done, 0);

    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), 16'($urandom),
             1'($urandom), 4'($urandom_range(0, 15)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 The block SHALL have these ports, one per line (name  direction  width  meaning):
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- abus  input  16  operand, latched on an accepted start.
- op  input  3  shift operation, latched on an accepted start.
- cin  input  1  carry-in, latched on an accepted start.
- amt  input  4  number of single-bit steps (0-15), latched on an accepted start.
- outbus  output  16  result register.
- cout  output  1  carry register (last bit shifted out).
- overflow  output  1  sticky overflow across all steps.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle completion pulse.
REQ-002 Clock is clk, reset is reset; one clock, synchronous active-high reset.

Function
REQ-003 op encoding SHALL be 000 NOP, 001 SHL, 010 SHR, 011 SAR, 100 RLC, 101 RRC; 110/111 invalid.
REQ-004 The block SHALL repeat one single-bit step per cycle. Each step uses the working register R and carry C:
- SHL: R={R[14:0],0}, C=R[15], ov=R[15]^R[14].
- SHR: R={0,R[15:1]}, C=R[0], ov=R[15].
- SAR: R={R[15],R[15:1]}, except R==0xFFFF gives 0x0000; C=R[0]; ov=0.
- RLC: R={R[14:0],C}, C=R[15], ov=R[15]^R[14].
- RRC: R={C,R[15:1]}, C=R[0], ov=R[15]^C(old).
REQ-005 overflow SHALL be the OR of the per-step ov values from the current operation only.
REQ-006 The FSM SHALL have three states:
- IDLE: on start, latch R=abus, C=cin, ov=0, count=amt, op. Go to SHIFT if amt!=0 and op is valid; otherwise go to DONE.
- SHIFT: perform one step and decrement count; go to DONE when count reaches 0.
- DONE: assert done for one cycle, then go to IDLE.
REQ-007 Latency from the start cycle to the done cycle SHALL be amt+1 cycles; amt=0 gives 1 cycle.
REQ-008 For amt=0 with a valid op, the block SHALL return outbus=abus, cout=0, overflow=0.
REQ-009 For NOP or an invalid op, the block SHALL return outbus=0, cout=0, overflow=0, with done after 1 cycle.
REQ-010 outbus/cout/overflow SHALL mirror R/C/ov at all times and SHALL hold their final values in IDLE until the next accepted start.
REQ-011 start SHALL be ignored while busy=1; no queuing.
REQ-012 A start in the same cycle as done SHALL be ignored; it is accepted only in IDLE.

Reset
REQ-013 While reset=1: state=IDLE; outbus=0x0000; cout=0; overflow=0; busy=0; done=0; count=0.
REQ-014 Reset SHALL take precedence over start and over any step in progress.
REQ-015 A reset mid-operation SHALL abort the operation with no done pulse.

Configuration
REQ-016 Macro SHIFT_SEQ_EARLY_EXIT_EN, when defined: in SHIFT, if R==0 and C==0 after a step, go to DONE immediately regardless of the remaining count.
- Results SHALL be bit-identical to the non-macro build; only latency shrinks.
REQ-017 Without SHIFT_SEQ_EARLY_EXIT_EN, latency SHALL always follow REQ-007.

Verification
REQ-018 SHL, abus=0x1234, cin=0, amt=3 -> outbus=0x91A0, cout=0, overflow=1; done 4 cycles after start.
REQ-019 SHR, abus=0x800F, amt=4 -> outbus=0x0800, cout=1, overflow=1. SAR, abus=0x8004, amt=2 -> outbus=0xE001, cout=0, overflow=0.
REQ-020 SAR, abus=0xFFFF, amt=1 -> outbus=0x0000, cout=1. RLC, abus=0x8000, cin=1, amt=1 -> outbus=0x0001, cout=1, overflow=1.
REQ-021 amt=0 SHL, abus=0xABCD -> outbus=0xABCD, cout=0; done 1 cycle after start.
- A second start during busy is ignored.
- reset asserted 2 cycles into an amt=8 operation -> outputs 0, no done pulse.
REQ-022 SHR, abus=0x0003, amt=15 -> outbus=0x0000, cout=0, overflow=0.
- done at cycle 4 with SHIFT_SEQ_EARLY_EXIT_EN defined.
- done at cycle 16 without it.
